// File: rtl/alu_ex_result_stage_pkg.sv
// Shared definitions for the ALU execute-result stage: result selects, trap FSM
// encoding, the buffered entry layout and the compare-resolution helper.
package alu_ex_result_stage_pkg;

  localparam logic [1:0] SEL_SUM = 2'd0;
  localparam logic [1:0] SEL_EQ  = 2'd1;
  localparam logic [1:0] SEL_NE  = 2'd2;
  localparam logic [1:0] SEL_LT  = 2'd3;

  localparam int EX_DW = 32;
  localparam int EX_RW = 5;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } ex_state_e;

  // Entry as held in the skid buffer, MSB first: {result, rd, wr_en}
  typedef struct packed {
    logic [EX_DW-1:0] result;
    logic [EX_RW-1:0] rd;
    logic             wr_en;
  } ex_entry_t;

  // Signed LT uses the true sign (sum MSB corrected by overflow); unsigned LT is a borrow
  function automatic logic lt_resolve(input logic sign, input logic neg,
                                      input logic ovf, input logic sub);
    logic lt;
    if (sign) begin
      lt = neg ^ ovf;
    end else begin
      lt = sub & ovf;
    end
    return lt;
  endfunction

endpackage

// File: rtl/alu_ex_result_stage_ex_skid_buf.sv
// Generic 2-entry valid/ready skid buffer: the main register drives the outputs,
// the skid register absorbs one entry while the consumer stalls.
module ex_skid_buf #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_flush,
  input  logic          i_valid,
  input  logic [PW-1:0] i_data,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [PW-1:0] o_data,
  output logic          o_skid_full,
  output logic          o_skid_full_nxt
);

  logic          r_main_v;
  logic [PW-1:0] r_main_d;
  logic          r_skid_v;
  logic [PW-1:0] r_skid_d;
  logic          w_push;
  logic          w_pop;
  logic          w_main_v_nxt;
  logic [PW-1:0] w_main_d_nxt;
  logic          w_skid_v_nxt;
  logic [PW-1:0] w_skid_d_nxt;

  // Next-state selection; a push is only honoured while the skid slot is free
  always_comb begin
    w_push       = i_valid & ~r_skid_v;
    w_pop        = r_main_v & i_ready;
    w_main_v_nxt = r_main_v;
    w_main_d_nxt = r_main_d;
    w_skid_v_nxt = r_skid_v;
    w_skid_d_nxt = r_skid_d;
    if (i_flush) begin
      w_main_v_nxt = 1'b0;
      w_skid_v_nxt = 1'b0;
    end else if (!r_main_v || w_pop) begin
      if (r_skid_v) begin
        w_main_v_nxt = 1'b1;
        w_main_d_nxt = r_skid_d;
        w_skid_v_nxt = 1'b0;
      end else if (w_push) begin
        w_main_v_nxt = 1'b1;
        w_main_d_nxt = i_data;
      end else begin
        w_main_v_nxt = 1'b0;
      end
    end else if (w_push) begin
      w_skid_v_nxt = 1'b1;
      w_skid_d_nxt = i_data;
    end else begin
      w_skid_v_nxt = r_skid_v;
    end
  end

  // Main and skid registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main_v <= 1'b0;
      r_main_d <= {PW{1'b0}};
      r_skid_v <= 1'b0;
      r_skid_d <= {PW{1'b0}};
    end else begin
      r_main_v <= w_main_v_nxt;
      r_main_d <= w_main_d_nxt;
      r_skid_v <= w_skid_v_nxt;
      r_skid_d <= w_skid_d_nxt;
    end
  end

  assign o_valid         = r_main_v;
  assign o_data          = r_main_d;
  assign o_skid_full     = r_skid_v;
  assign o_skid_full_nxt = w_skid_v_nxt;

endmodule

// File: rtl/alu_ex_result_stage.sv
// Execute-to-memory stage: resolves compare results and overflow traps from the
// adder outputs, buffers results in a skid buffer and holds traps until acknowledged.
module alu_ex_result_stage
  import alu_ex_result_stage_pkg::*;
#(
  parameter int DW = EX_DW,
  parameter int RW = EX_RW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_sum,
  input  logic          in_zero,
  input  logic          in_ovf,
  input  logic          in_neg,
  input  logic          in_sign,
  input  logic          in_sub,
  input  logic [1:0]    in_sel,
  input  logic          in_trap_en,
  input  logic [RW-1:0] in_rd,
  input  logic          in_wr_en,
  input  logic [31:0]   in_pc,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_result,
  output logic [RW-1:0] out_rd,
  output logic          out_wr_en,
  output logic          exc_req,
  output logic [31:0]   exc_pc,
  input  logic          exc_ack
);

  localparam int PW = DW + RW + 1;

  logic [DW-1:0] w_result;
  logic          w_lt;
  logic          w_trap;
  logic          w_acc;
  logic          w_push;
  logic          w_trap_take;
  logic          w_run_nxt;
  logic          w_skid_full;
  logic          w_skid_full_nxt;
  logic [PW-1:0] w_main_d;
  ex_state_e     r_state;
  logic          r_in_ready;
  logic          r_exc_req;
  logic [31:0]   r_exc_pc;

  // Result and trap resolution; a flushed input neither stores nor traps
  always_comb begin
    w_lt = lt_resolve(in_sign, in_neg, in_ovf, in_sub);
    case (in_sel)
      SEL_SUM: w_result = in_sum;
      SEL_EQ:  w_result = {{(DW-1){1'b0}}, in_zero};
      SEL_NE:  w_result = {{(DW-1){1'b0}}, ~in_zero};
      SEL_LT:  w_result = {{(DW-1){1'b0}}, w_lt};
      default: w_result = in_sum;
    endcase
    w_trap      = in_trap_en & in_sign & in_ovf & (in_sel == SEL_SUM);
    w_acc       = in_valid & r_in_ready;
    w_push      = w_acc & ~w_trap & ~flush;
    w_trap_take = w_acc & w_trap & ~flush;
  end

  // Whether the FSM will be in RUN after this edge, used to pre-compute in_ready
  always_comb begin
    case (r_state)
      ST_RUN:  w_run_nxt = ~w_trap_take;
      ST_TRAP: w_run_nxt = exc_ack;
      default: w_run_nxt = 1'b1;
    endcase
  end

  // Trap FSM with registered exception outputs and registered in_ready
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_exc_req  <= 1'b0;
      r_exc_pc   <= 32'd0;
      r_in_ready <= 1'b1;
    end else begin
      r_in_ready <= ~w_skid_full_nxt & w_run_nxt;
      case (r_state)
        ST_RUN: begin
          if (w_trap_take) begin
            r_state   <= ST_TRAP;
            r_exc_req <= 1'b1;
            r_exc_pc  <= in_pc;
          end else begin
            r_state   <= ST_RUN;
          end
        end
        ST_TRAP: begin
          if (exc_ack) begin
            r_state   <= ST_RUN;
            r_exc_req <= 1'b0;
          end else begin
            r_state   <= ST_TRAP;
          end
        end
        default: begin
          r_state   <= ST_RUN;
          r_exc_req <= 1'b0;
        end
      endcase
    end
  end

  ex_skid_buf #(
    .PW (PW)
  ) u_skid (
    .clk             (clk),
    .reset           (reset),
    .i_flush         (flush),
    .i_valid         (w_push),
    .i_data          ({w_result, in_rd, in_wr_en}),
    .i_ready         (out_ready),
    .o_valid         (out_valid),
    .o_data          (w_main_d),
    .o_skid_full     (w_skid_full),
    .o_skid_full_nxt (w_skid_full_nxt)
  );

  assign in_ready   = r_in_ready;
  assign out_result = w_main_d[PW-1 -: DW];
  assign out_rd     = w_main_d[RW:1];
  assign out_wr_en  = w_main_d[0];
  assign exc_req    = r_exc_req;
  assign exc_pc     = r_exc_pc;

  // Skid occupancy is already folded into r_in_ready; kept visible for debug probes
  logic w_unused_ok;
  assign w_unused_ok = w_skid_full;

endmodule

// File: tb/tb_alu_ex_result_stage.sv
// Directed bench for alu_ex_result_stage: inputs change and outputs are sampled
// 1 ns after each rising edge.
module tb_alu_ex_result_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_sum;
  logic        in_zero;
  logic        in_ovf;
  logic        in_neg;
  logic        in_sign;
  logic        in_sub;
  logic [1:0]  in_sel;
  logic        in_trap_en;
  logic [4:0]  in_rd;
  logic        in_wr_en;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_wr_en;
  logic        exc_req;
  logic [31:0] exc_pc;
  logic        exc_ack;

  int n_pass;
  int n_total;

  alu_ex_result_stage dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sum     (in_sum),
    .in_zero    (in_zero),
    .in_ovf     (in_ovf),
    .in_neg     (in_neg),
    .in_sign    (in_sign),
    .in_sub     (in_sub),
    .in_sel     (in_sel),
    .in_trap_en (in_trap_en),
    .in_rd      (in_rd),
    .in_wr_en   (in_wr_en),
    .in_pc      (in_pc),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .out_wr_en  (out_wr_en),
    .exc_req    (exc_req),
    .exc_pc     (exc_pc),
    .exc_ack    (exc_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [1:0] sel, input logic [31:0] sum,
                     input logic zero, input logic ovf, input logic sign, input logic sub,
                     input logic trap_en, input logic [4:0] rd, input logic we,
                     input logic [31:0] pc);
    in_valid   = v;
    in_sel     = sel;
    in_sum     = sum;
    in_zero    = zero;
    in_ovf     = ovf;
    in_sign    = sign;
    in_neg     = sign & sum[31];
    in_sub     = sub;
    in_trap_en = trap_en;
    in_rd      = rd;
    in_wr_en   = we;
    in_pc      = pc;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    reset = 1'b0;
    flush = 1'b0;
    exc_ack = 1'b0;
    out_ready = 1'b1;
    drv(1'b0, 2'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0);
    #1 reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_result", 64'(out_result), 64'd0);
    chk("rst_out_rd", 64'(out_rd), 64'd0);
    chk("rst_out_wr_en", 64'(out_wr_en), 64'd0);
    chk("rst_exc_req", 64'(exc_req), 64'd0);
    chk("rst_exc_pc", 64'(exc_pc), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Back-to-back results at full throughput
    drv(1'b1, 2'd0, 32'h0000_0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1, 32'h100);
    tick();
    chk("sum_valid", 64'(out_valid), 64'd1);
    chk("sum_result", 64'(out_result), 64'd5);
    chk("sum_rd", 64'(out_rd), 64'd3);
    chk("sum_wr_en", 64'(out_wr_en), 64'd1);
    chk("sum_in_ready", 64'(in_ready), 64'd1);
    drv(1'b1, 2'd1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4, 1'b0, 32'h104);
    tick();
    chk("eq_valid", 64'(out_valid), 64'd1);
    chk("eq_result", 64'(out_result), 64'd1);
    chk("eq_rd", 64'(out_rd), 64'd4);
    chk("eq_wr_en", 64'(out_wr_en), 64'd0);
    drv(1'b1, 2'd2, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 1'b1, 32'h108);
    tick();
    chk("ne_result", 64'(out_result), 64'd0);
    chk("ne_rd", 64'(out_rd), 64'd5);
    drv(1'b1, 2'd3, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd6, 1'b1, 32'h10c);
    tick();
    chk("slt_ovf_result", 64'(out_result), 64'd0);
    drv(1'b1, 2'd3, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd7, 1'b1, 32'h110);
    tick();
    chk("slt_neg_result", 64'(out_result), 64'd1);
    drv(1'b1, 2'd3, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd8, 1'b1, 32'h114);
    tick();
    chk("ult_borrow_result", 64'(out_result), 64'd1);
    drv(1'b1, 2'd3, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 1'b1, 32'h118);
    tick();
    chk("ult_nosub_result", 64'(out_result), 64'd0);
    drv(1'b1, 2'd0, 32'h0000_1234, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd10, 1'b1, 32'h11c);
    tick();
    chk("addu_result", 64'(out_result), 64'h1234);
    chk("addu_no_exc", 64'(exc_req), 64'd0);
    in_valid = 1'b0;
    tick();
    chk("idle_valid", 64'(out_valid), 64'd0);

    // Backpressure: A held, B in skid, C waits for space
    out_ready = 1'b0;
    drv(1'b1, 2'd0, 32'h0000_000A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd10, 1'b1, 32'h200);
    tick();
    chk("bp_a_result", 64'(out_result), 64'hA);
    chk("bp_a_in_ready", 64'(in_ready), 64'd1);
    drv(1'b1, 2'd0, 32'h0000_000B, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd11, 1'b1, 32'h204);
    tick();
    chk("bp_hold_a", 64'(out_result), 64'hA);
    chk("bp_b_in_ready", 64'(in_ready), 64'd0);
    drv(1'b1, 2'd0, 32'h0000_000C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd12, 1'b1, 32'h208);
    tick();
    chk("bp_hold_a2", 64'(out_result), 64'hA);
    chk("bp_hold_rd", 64'(out_rd), 64'd10);
    chk("bp_c_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    tick();
    chk("bp_b_result", 64'(out_result), 64'hB);
    chk("bp_b_rd", 64'(out_rd), 64'd11);
    chk("bp_release_ready", 64'(in_ready), 64'd1);
    tick();
    chk("bp_c_result", 64'(out_result), 64'hC);
    chk("bp_c_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    tick();
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Overflow trap and acknowledge
    drv(1'b1, 2'd0, 32'h7FFF_0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 32'h0040_0010);
    tick();
    chk("trap_not_emitted", 64'(out_valid), 64'd0);
    chk("trap_exc_req", 64'(exc_req), 64'd1);
    chk("trap_exc_pc", 64'(exc_pc), 64'h0040_0010);
    chk("trap_in_ready", 64'(in_ready), 64'd0);
    drv(1'b1, 2'd0, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 32'h0040_0014);
    tick();
    chk("trap_hold_req", 64'(exc_req), 64'd1);
    chk("trap_hold_pc", 64'(exc_pc), 64'h0040_0010);
    chk("trap_blocks_input", 64'(out_valid), 64'd0);
    in_valid = 1'b0;
    exc_ack = 1'b1;
    tick();
    exc_ack = 1'b0;
    chk("ack_exc_req", 64'(exc_req), 64'd0);
    chk("ack_in_ready", 64'(in_ready), 64'd1);

    // Flush with main and skid full plus a trapping input
    out_ready = 1'b0;
    drv(1'b1, 2'd0, 32'h0000_00D1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 32'h300);
    tick();
    drv(1'b1, 2'd0, 32'h0000_00D2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 1'b1, 32'h304);
    tick();
    chk("fl_full_in_ready", 64'(in_ready), 64'd0);
    drv(1'b1, 2'd0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 32'h308);
    flush = 1'b1;
    tick();
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_no_exc", 64'(exc_req), 64'd0);
    chk("fl_in_ready", 64'(in_ready), 64'd1);
    flush = 1'b0;
    drv(1'b1, 2'd0, 32'h0000_00D3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd4, 1'b1, 32'h30c);
    tick();
    chk("fl2_main_loaded", 64'(out_result), 64'hD3);
    drv(1'b1, 2'd0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 32'h310);
    flush = 1'b1;
    tick();
    chk("fl2_out_valid", 64'(out_valid), 64'd0);
    chk("fl2_trap_suppressed", 64'(exc_req), 64'd0);
    flush = 1'b0;
    out_ready = 1'b1;

    // Flush leaves a pending trap; flush with exc_ack clears it
    drv(1'b1, 2'd0, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd6, 1'b1, 32'h0040_0020);
    tick();
    in_valid = 1'b0;
    flush = 1'b1;
    tick();
    chk("fl_keeps_trap", 64'(exc_req), 64'd1);
    exc_ack = 1'b1;
    tick();
    flush = 1'b0;
    exc_ack = 1'b0;
    chk("fl_ack_clears", 64'(exc_req), 64'd0);
    chk("fl_ack_in_ready", 64'(in_ready), 64'd1);

    // Asynchronous reset with a held result and a pending trap
    out_ready = 1'b0;
    drv(1'b1, 2'd0, 32'h0000_00E1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd9, 1'b1, 32'h400);
    tick();
    drv(1'b1, 2'd0, 32'h8000_0001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 32'h0040_0030);
    tick();
    in_valid = 1'b0;
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    chk("pre_rst_exc", 64'(exc_req), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_result", 64'(out_result), 64'd0);
    chk("arst_out_rd", 64'(out_rd), 64'd0);
    chk("arst_exc_req", 64'(exc_req), 64'd0);
    chk("arst_exc_pc", 64'(exc_pc), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    tick();
    reset = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
